// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared types, funct3 encodings and helpers for the RV32M sequencer
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int MD_ITERS = 32;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] opa;
        logic [31:0] opb;
    } md_req_t;

    function automatic logic md_signed_a(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic md_signed_b(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_if
// Brief    : EX-stage <-> M-extension sequencer request/response bundle
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic            kill;
    logic            stall;
    logic            result_valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, opa, opb, kill,
        input  stall, result_valid, result
    );

    modport slave (
        input  start, op, opa, opb, kill,
        output stall, result_valid, result
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_core.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_core
// Brief    : Unsigned shift-add multiply / restoring divide datapath, one bit
//            per step; nxt_hi/nxt_lo show the state after the pending step
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_core #(
    parameter int XLEN = 32
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            load,
    input  wire logic            step,
    input  wire logic            is_div,
    input  wire logic [XLEN-1:0] ld_m,
    input  wire logic [XLEN-1:0] ld_q,
    output logic      [XLEN-1:0] nxt_hi,
    output logic      [XLEN-1:0] nxt_lo
);
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_mq;
    logic [XLEN-1:0] r_m;
    logic            r_div;

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shl;
    logic [XLEN-1:0] w_diff;
    logic            w_ge;

    always_comb begin
        w_sum  = {1'b0, r_acc} + {1'b0, r_m};
        w_shl  = {r_acc, r_mq[XLEN-1]};
        w_ge   = (w_shl >= {1'b0, r_m});
        // Partial remainder stays below the divisor, so the difference fits XLEN bits
        w_diff = w_shl[XLEN-1:0] - r_m;
        nxt_hi = '0;
        nxt_lo = '0;
        if (r_div) begin
            nxt_hi = w_ge ? w_diff : w_shl[XLEN-1:0];
            nxt_lo = {r_mq[XLEN-2:0], w_ge};
        end else if (r_mq[0]) begin
            nxt_hi = w_sum[XLEN:1];
            nxt_lo = {w_sum[0], r_mq[XLEN-1:1]};
        end else begin
            nxt_hi = {1'b0, r_acc[XLEN-1:1]};
            nxt_lo = {r_acc[0], r_mq[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_mq  <= '0;
            r_m   <= '0;
            r_div <= 1'b0;
        end else if (load) begin
            r_acc <= '0;
            r_mq  <= ld_q;
            r_m   <= ld_m;
            r_div <= is_div;
        end else if (step) begin
            r_acc <= nxt_hi;
            r_mq  <= nxt_lo;
        end
    end
endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_ctrl
// Brief    : RV32M execute-stage sequencer: FSM, sign fix-up, special cases.
//            Optional macro MULDIV_FAST_MUL_EN: single-cycle multiplies.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ITERS = MD_ITERS
) (
    input  wire logic clk,
    input  wire logic reset,
    muldiv_if.slave   bus
);
    md_state_t       r_state;
    logic [4:0]      r_cnt;
    logic [2:0]      r_op;
    logic            r_neg;
    logic            r_result_valid;
    logic [XLEN-1:0] r_result;

    md_req_t         w_req;
    logic            w_neg_a, w_neg_b;
    logic [XLEN-1:0] w_mag_a, w_mag_b;
    logic            w_div_zero, w_ovf, w_special;
    logic [XLEN-1:0] w_special_res;
    logic            w_accept, w_load, w_step, w_stall;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_res;
    logic [XLEN-1:0] w_hi, w_lo;
    logic [2*XLEN-1:0] w_prod, w_prod_fix;
    logic [XLEN-1:0] w_div_raw, w_div_fix, w_final;

    assign w_req   = '{op: bus.op, opa: bus.opa, opb: bus.opb};
    assign w_neg_a = md_signed_a(w_req.op) & w_req.opa[XLEN-1];
    assign w_neg_b = md_signed_b(w_req.op) & w_req.opb[XLEN-1];
    assign w_mag_a = w_neg_a ? (~w_req.opa + 1'b1) : w_req.opa;
    assign w_mag_b = w_neg_b ? (~w_req.opb + 1'b1) : w_req.opb;

    // op[2] selects divide, op[1] selects remainder within the divide group
    assign w_div_zero = w_req.op[2] & (w_req.opb == '0);
    assign w_ovf      = ((w_req.op == MD_DIV) || (w_req.op == MD_REM))
                      & (w_req.opa == {1'b1, {(XLEN-1){1'b0}}})
                      & (w_req.opb == '1);
    assign w_special  = w_div_zero | w_ovf;
    assign w_special_res = w_div_zero ? (w_req.op[1] ? w_req.opa : '1)
                                      : (w_req.op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fa, w_fb, w_fp;
    assign w_fa       = {{XLEN{w_neg_a}}, w_req.opa};
    assign w_fb       = {{XLEN{w_neg_b}}, w_req.opb};
    assign w_fp       = w_fa * w_fb;
    assign w_fast     = ~w_req.op[2];
    assign w_fast_res = (w_req.op == MD_MUL) ? w_fp[XLEN-1:0] : w_fp[2*XLEN-1:XLEN];
`else
    assign w_fast     = 1'b0;
    assign w_fast_res = '0;
`endif

    assign w_accept = (r_state == MD_IDLE) & bus.start & ~bus.kill & ~reset;
    assign w_stall  = w_accept | ((r_state == MD_BUSY) & ~bus.kill & ~reset);
    assign w_load   = w_accept & ~w_special & ~w_fast;
    assign w_step   = (r_state == MD_BUSY) & ~bus.kill;

    muldiv_core #(.XLEN(XLEN)) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (w_load),
        .step   (w_step),
        .is_div (w_req.op[2]),
        .ld_m   (w_req.op[2] ? w_mag_b : w_mag_a),
        .ld_q   (w_req.op[2] ? w_mag_a : w_mag_b),
        .nxt_hi (w_hi),
        .nxt_lo (w_lo)
    );

    assign w_prod     = {w_hi, w_lo};
    assign w_prod_fix = r_neg ? (~w_prod + 1'b1) : w_prod;
    assign w_div_raw  = r_op[1] ? w_hi : w_lo;
    assign w_div_fix  = r_neg ? (~w_div_raw + 1'b1) : w_div_raw;
    assign w_final    = r_op[2] ? w_div_fix
                      : ((r_op == MD_MUL) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= MD_IDLE;
            r_cnt          <= '0;
            r_op           <= '0;
            r_neg          <= 1'b0;
            r_result_valid <= 1'b0;
            r_result       <= '0;
        end else begin
            r_result_valid <= 1'b0;
            if (bus.kill) begin
                r_state <= MD_IDLE;
            end else begin
                case (r_state)
                    MD_IDLE: begin
                        if (bus.start) begin
                            if (w_special) begin
                                r_result       <= w_special_res;
                                r_result_valid <= 1'b1;
                                r_state        <= MD_DONE;
                            end else if (w_fast) begin
                                r_result       <= w_fast_res;
                                r_result_valid <= 1'b1;
                                r_state        <= MD_DONE;
                            end else begin
                                r_op    <= w_req.op;
                                // Remainder follows the dividend; everything else the sign XOR
                                r_neg   <= (w_req.op[2] & w_req.op[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);
                                r_cnt   <= '0;
                                r_state <= MD_BUSY;
                            end
                        end
                    end
                    MD_BUSY: begin
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'(ITERS - 1)) begin
                            r_result       <= w_final;
                            r_result_valid <= 1'b1;
                            r_state        <= MD_DONE;
                        end
                    end
                    MD_DONE: r_state <= MD_IDLE;
                    default: r_state <= MD_IDLE;
                endcase
            end
        end
    end

    assign bus.stall        = w_stall;
    assign bus.result_valid = r_result_valid;
    assign bus.result       = r_result;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_ctrl
// Brief    : Scoreboard bench for muldiv_ctrl with an arithmetic reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_if bus ();
    muldiv_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        prev_rv = 1'b0;
    logic [31:0] last_res = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_, ua, ub, p;
        logic   ovf;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            MD_MUL:    begin p = ua * ub;  return p[31:0];  end
            MD_MULH:   begin p = sa * sb_; return p[63:32]; end
            MD_MULHSU: begin p = sa * ub;  return p[63:32]; end
            MD_MULHU:  begin p = ua * ub;  return p[63:32]; end
            MD_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            MD_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0)) return 1;
        if ((op == MD_DIV || op == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return 33;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after DONE
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n, lat;
        lat = ref_lat(op, a, b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
        sb.push_back('{res: ref_md(op, a, b), cyc: cyc + lat});
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.stall) break;
            n++;
        end
        check("stall_len", 32'(n), 32'(lat));
        last_res = ref_md(op, a, b);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            prev_rv = 1'b0;
        end else begin
            if (bus.result_valid) begin
                check("rv_single_cycle", {31'd0, prev_rv}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got result_valid with result %h, want none", bus.result);
                end else begin
                    e = sb.pop_front();
                    check("result", bus.result, e.res);
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            prev_rv = bus.result_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held;
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.op    = MD_MUL;
        bus.opa   = 32'd5;
        bus.opb   = 32'd5;
        bus.kill  = 1'b0;
        @(negedge clk);
        check("stall_in_reset", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        check("reset_result", bus.result, 32'd0);
        check("reset_valid", {31'd0, bus.result_valid}, 32'd0);
        reset     = 1'b0;
        bus.start = 1'b0;
        idle(1);

        // Directed cases, issued back to back
        issue(MD_MUL,    32'd7,          32'hFFFF_FFFD);
        issue(MD_DIV,    32'hFFFF_FFF9,  32'd2);
        issue(MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF);
        issue(MD_MULHSU, 32'hFFFF_FFFF,  32'd2);
        issue(MD_REM,    32'hFFFF_FFF9,  32'd2);
        issue(MD_DIVU,   32'd100,        32'd7);
        issue(MD_REMU,   32'd100,        32'd7);
        issue(MD_DIVU,   32'h1234_5678,  32'd0);
        issue(MD_REM,    32'd5,          32'd0);
        issue(MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF);
        issue(MD_REM,    32'h8000_0000,  32'hFFFF_FFFF);
        issue(MD_MULH,   32'h8000_0000,  32'h8000_0000);
        idle(2);

        // Kill at counter 10
        held      = last_res;
        bus.start = 1'b1;
        bus.op    = MD_DIVU;
        bus.opa   = 32'd1000;
        bus.opb   = 32'd7;
        repeat (11) @(posedge clk);
        #1 bus.kill = 1'b1;
        @(negedge clk);
        check("stall_on_kill", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        bus.kill  = 1'b0;
        bus.start = 1'b0;
        idle(3);
        @(negedge clk);
        check("kill_result_held", bus.result, held);
        idle(1);
        issue(MD_DIVU, 32'd9, 32'd3);

        // Kill together with start in IDLE is not accepted
        bus.start = 1'b1;
        bus.kill  = 1'b1;
        bus.op    = MD_DIV;
        bus.opa   = 32'd50;
        bus.opb   = 32'd5;
        @(negedge clk);
        check("stall_start_kill", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        idle(3);

        // Reset at counter 20
        bus.start = 1'b1;
        bus.op    = MD_MUL;
        bus.opa   = 32'd123;
        bus.opb   = 32'd456;
        repeat (21) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("stall_reset_busy", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("post_reset_result", bus.result, 32'd0);
        check("post_reset_valid", {31'd0, bus.result_valid}, 32'd0);
        check("post_reset_stall", {31'd0, bus.stall}, 32'd0);
        last_res = '0;
        idle(1);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  rop;
            logic [31:0] ra, rb;
            rop = 3'($urandom_range(0, 7));
            ra  = pick();
            rb  = pick();
            issue(rop, ra, rb);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end

        idle(4);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
